// File: rtl/led_pkg.sv
// led_pkg: scheduler state encoding and default parameter values shared by the BCM scheduler files.
package led_pkg;
  localparam int DEF_ROW_BITS     = 5;
  localparam int DEF_PLANES       = 4;
  localparam int DEF_BASE_TICKS   = 16;
  localparam int DEF_BLANK_CYCLES = 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_WAIT,
    S_BLANK,
    S_LATCH,
    S_UNBLANK
  } state_e;
endpackage

// File: rtl/bcm_timer.sv
// bcm_timer: loadable down-counter that parks at zero and flags it.
module bcm_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/led_bcm_scheduler.sv
// led_bcm_scheduler: BCM row/bit-plane scheduler; shifts the next plane while the current one is lit
// and sequences HUB75 BLANK, LATCH and row address.
module led_bcm_scheduler
  import led_pkg::*;
#(
  parameter int ROW_BITS     = DEF_ROW_BITS,
  parameter int PLANES       = DEF_PLANES,
  parameter int BASE_TICKS   = DEF_BASE_TICKS,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                shift_req,
  output logic [ROW_BITS-1:0] shift_row,
  output logic [2:0]          shift_plane,
  input  logic                shift_done,
  output logic                led_blank,
  output logic                led_latch,
  output logic [ROW_BITS-1:0] led_addr,
  output logic [15:0]         frame,
  output logic                frame_strobe
);
  localparam int TW = $clog2(BASE_TICKS) + PLANES;
  localparam int BW = $clog2(BLANK_CYCLES) + 1;
  localparam logic [2:0] LAST_PLANE = 3'(PLANES - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);

  state_e state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d, srow_q, srow_d, addr_q, addr_d, nrow;
  logic [2:0] plane_q, plane_d, splane_q, splane_d, dplane_q, dplane_d, nplane;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [15:0] frame_q, frame_d;
  logic [TW-1:0] tval;
  logic req_q, req_d, shifted_q, shifted_d, strobe_q, strobe_d, blank_q, latch_q;
  logic acc, last_plane, wrap, tload, tzero;

  assign acc        = shift_done && req_q;
  assign last_plane = plane_q == LAST_PLANE;
  assign wrap       = last_plane && row_q == '1;
  assign nplane     = last_plane ? 3'd0 : plane_q + 3'd1;
  assign nrow       = last_plane ? row_q + ROW_BITS'(1) : row_q;
  assign tval       = (TW'(BASE_TICKS) << dplane_q) - TW'(1);

  bcm_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tload),
    .load_val_i(tval),
    .en_i      (state_q == S_WAIT),
    .zero_o    (tzero)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    plane_d   = plane_q;
    req_d     = acc ? 1'b0 : req_q;
    srow_d    = srow_q;
    splane_d  = splane_q;
    shifted_d = shifted_q;
    bcnt_d    = bcnt_q;
    addr_d    = addr_q;
    dplane_d  = dplane_q;
    frame_d   = frame_q;
    strobe_d  = 1'b0;
    tload     = 1'b0;
    case (state_q)
      S_IDLE: if (enable) begin
        req_d    = 1'b1;
        srow_d   = row_q;
        splane_d = plane_q;
        state_d  = S_PRIME;
      end
      S_PRIME: if (acc) begin
        bcnt_d  = BLANK_LOAD;
        state_d = S_BLANK;
      end
      S_WAIT: begin
        shifted_d = shifted_q || acc;
        if (tzero && (shifted_q || acc)) begin
          bcnt_d  = BLANK_LOAD;
          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        bcnt_d  = bcnt_q - BW'(1);
        state_d = bcnt_q == '0 ? S_LATCH : S_BLANK;
      end
      S_LATCH: begin
        addr_d   = row_q;
        dplane_d = plane_q;
        state_d  = S_UNBLANK;
      end
      S_UNBLANK: begin
        frame_d  = wrap ? frame_q + 16'd1 : frame_q;
        strobe_d = wrap;
        // dropping enable here parks the scan so the next start begins at (0,0)
        row_d    = enable ? nrow : '0;
        plane_d  = enable ? nplane : 3'd0;
        state_d  = enable ? S_WAIT : S_IDLE;
        if (enable) begin
          tload     = 1'b1;
          req_d     = 1'b1;
          srow_d    = nrow;
          splane_d  = nplane;
          shifted_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      plane_q   <= '0;
      req_q     <= 1'b0;
      srow_q    <= '0;
      splane_q  <= '0;
      shifted_q <= 1'b0;
      bcnt_q    <= '0;
      addr_q    <= '0;
      dplane_q  <= '0;
      frame_q   <= '0;
      strobe_q  <= 1'b0;
      blank_q   <= 1'b1;
      latch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      req_q     <= req_d;
      srow_q    <= srow_d;
      splane_q  <= splane_d;
      shifted_q <= shifted_d;
      bcnt_q    <= bcnt_d;
      addr_q    <= addr_d;
      dplane_q  <= dplane_d;
      frame_q   <= frame_d;
      strobe_q  <= strobe_d;
      blank_q   <= state_d != S_WAIT;
      latch_q   <= state_d == S_LATCH;
    end
  end

  assign shift_req    = req_q;
  assign shift_row    = srow_q;
  assign shift_plane  = splane_q;
  assign led_blank    = blank_q;
  assign led_latch    = latch_q;
  assign led_addr     = addr_q;
  assign frame        = frame_q;
  assign frame_strobe = strobe_q;
endmodule
